// File: rtl/montgomery_pkg.sv
`default_nettype none
// ============================================================================
// montgomery_pkg
// Shared types and constants for the Montgomery constant server and its
// per-constant block store.
//   REGISTER_SIZE : bits per block
//   R             : Montgomery radix width in bits
//   NUM_BLOCKS    : blocks per constant
//   block_t       : one constant block
//   addr_t        : block index, 0 = least significant block
//   srv_state_t   : session FSM encoding
//   K_SEL / N_SEL : load selector encoding
// Revision: 1.0
// ============================================================================
package montgomery_pkg;

  localparam int REGISTER_SIZE = 32;
  localparam int R             = 4096;
  localparam int NUM_BLOCKS    = R / REGISTER_SIZE;
  localparam int ADDR_W        = $clog2(NUM_BLOCKS);

  typedef logic [REGISTER_SIZE-1:0] block_t;
  typedef logic [ADDR_W-1:0]        addr_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } srv_state_t;

  localparam logic K_SEL = 1'b0;
  localparam logic N_SEL = 1'b1;

endpackage
`default_nettype wire

// File: rtl/constant_block_store.sv
`default_nettype none
// ============================================================================
// constant_block_store
// Storage for one Montgomery constant plus its streaming read pointer.
//   clk, rst_n        : clock, asynchronous active-low reset
//   wr_en/addr/data   : block write port (gated to idle by the parent)
//   clear             : force pointer and pass counter back to block 0
//   consume           : advance pointer (gated to an active session)
//   block             : combinational read of storage[ptr]
//   full              : every block has been written since reset
//   overrun           : combinational, consume arrived with passes exhausted
// Revision: 1.0
// ============================================================================
module constant_block_store
  import montgomery_pkg::*;
#(
  parameter int PASSES = 1
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   wr_en,
  input  addr_t  wr_addr,
  input  block_t wr_data,
  input  logic   clear,
  input  logic   consume,
  output block_t block,
  output logic   full,
  output logic   overrun
);

  localparam int    PASS_W = $clog2(PASSES + 1);
  localparam addr_t LAST   = addr_t'(NUM_BLOCKS - 1);

  block_t              mem [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] loaded;
  addr_t               ptr;
  logic [PASS_W-1:0]   pass;

  // Storage is deliberately left unreset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loaded <= '0;
    end else if (wr_en) begin
      loaded[wr_addr] <= 1'b1;
    end
  end

  // Once the last allowed sweep has wrapped, the pointer is already parked
  // at 0; further consumes leave it there and are flagged.
  assign overrun = consume && (pass == PASS_W'(PASSES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr  <= '0;
      pass <= '0;
    end else if (clear) begin
      ptr  <= '0;
      pass <= '0;
    end else if (consume && !overrun) begin
      if (ptr == LAST) begin
        ptr  <= '0;
        pass <= pass + 1'b1;
      end else begin
        ptr  <= ptr + 1'b1;
      end
    end
  end

  assign block = mem[ptr];
  assign full  = &loaded;

endmodule
`default_nettype wire

// File: rtl/montgomery_constant_server.sv
`default_nettype none
// ============================================================================
// montgomery_constant_server
// Streams the per-key constants k and N block by block into the reduce stage
// for one reduction session, advancing on the reduce stage's consume strobes.
//   clk_in, rst_n_in     : clock, asynchronous active-low reset
//   t_valid_in           : first T block of a session (reduce valid_in)
//   consumed_k_in/N_in   : block-consumed strobes from the reduce stage
//   reduce_final_in      : reduce stage finished the session
//   k_block_out/n_block_out : current k / N blocks
//   load_*_in            : constant write port, accepted only while idle
//   ready_out            : idle with both constants fully loaded
//   busy_out             : session active
//   load_err_out         : pulse, load attempted during a session
//   overrun_err_out      : pulse, consume beyond allowed passes, consume
//                          while idle, or session start while not ready
// Revision: 1.0
// ============================================================================
module montgomery_constant_server
  import montgomery_pkg::*;
#(
  parameter int K_PASSES = 1,
  parameter int N_PASSES = 3
) (
  input  logic   clk_in,
  input  logic   rst_n_in,
  input  logic   t_valid_in,
  input  logic   consumed_k_in,
  input  logic   consumed_N_in,
  input  logic   reduce_final_in,
  output block_t k_block_out,
  output block_t n_block_out,
  input  logic   load_valid_in,
  input  logic   load_sel_in,
  input  addr_t  load_addr_in,
  input  block_t load_data_in,
  output logic   ready_out,
  output logic   busy_out,
  output logic   load_err_out,
  output logic   overrun_err_out
);

  srv_state_t state, state_next;

  logic k_full, n_full;
  logic k_over, n_over;
  logic idle;
  logic clear_ptrs;
  logic consume_k, consume_n;
  logic wr_k, wr_n;
  logic load_err_next, overrun_err_next;

  assign idle      = (state == IDLE);
  assign ready_out = idle && k_full && n_full;
  assign busy_out  = !idle;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next       = state;
    clear_ptrs       = 1'b0;
    consume_k        = 1'b0;
    consume_n        = 1'b0;
    wr_k             = 1'b0;
    wr_n             = 1'b0;
    load_err_next    = 1'b0;
    overrun_err_next = 1'b0;
    case (state)
      IDLE: begin
        clear_ptrs       = 1'b1;
        wr_k             = load_valid_in && (load_sel_in == K_SEL);
        wr_n             = load_valid_in && (load_sel_in == N_SEL);
        overrun_err_next = consumed_k_in || consumed_N_in ||
                           (t_valid_in && !ready_out);
        if (t_valid_in && ready_out) begin
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        load_err_next = load_valid_in;
        if (reduce_final_in) begin
          // A simultaneous t_valid starts the next session straight away.
          clear_ptrs = 1'b1;
          state_next = t_valid_in ? ACTIVE : IDLE;
        end else begin
          consume_k        = consumed_k_in;
          consume_n        = consumed_N_in;
          overrun_err_next = k_over || n_over;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      load_err_out    <= 1'b0;
      overrun_err_out <= 1'b0;
    end else begin
      load_err_out    <= load_err_next;
      overrun_err_out <= overrun_err_next;
    end
  end

  constant_block_store #(.PASSES(K_PASSES)) u_k_store (
    .clk     (clk_in),
    .rst_n   (rst_n_in),
    .wr_en   (wr_k),
    .wr_addr (load_addr_in),
    .wr_data (load_data_in),
    .clear   (clear_ptrs),
    .consume (consume_k),
    .block   (k_block_out),
    .full    (k_full),
    .overrun (k_over)
  );

  constant_block_store #(.PASSES(N_PASSES)) u_n_store (
    .clk     (clk_in),
    .rst_n   (rst_n_in),
    .wr_en   (wr_n),
    .wr_addr (load_addr_in),
    .wr_data (load_data_in),
    .clear   (clear_ptrs),
    .consume (consume_n),
    .block   (n_block_out),
    .full    (n_full),
    .overrun (n_over)
  );

endmodule
`default_nettype wire
